// File: rtl/reg_wb_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Holds the register-file geometry, the long-unit queue depth and the write-enable polarity.
package reg_wb_sched_pkg;

  localparam int CPU_WIDTH        = 16;
  localparam int NREG             = 8;
  localparam int AW               = 3;
  localparam int LQ_DEPTH_DEFAULT = 2;

  // Active level of the register-file write enable.
  localparam logic REGWE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LQ   = 2'd2,
    SRC_DBG  = 2'd3
  } wb_src_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] one;
    one = {{(NREG-1){1'b0}}, 1'b1};
    return one << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds long-unit results until the write port is free.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module wb_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so plain pointer increments wrap correctly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/reg_wb_sched.sv
// Writeback scheduler: arbitrates the register-file write port between ALU, long unit
// and debug, and keeps the scoreboard of registers awaiting a long-latency result.
module reg_wb_sched
  import reg_wb_sched_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        issue_rs,
  input  logic                 issue_uses_rd,
  input  logic                 issue_uses_rs,
  input  logic                 issue_writes,
  input  logic                 issue_long,
  output logic                 issue_stall,
  input  logic                 alu_wb_valid,
  input  logic [AW-1:0]        alu_wb_addr,
  input  logic [CPU_WIDTH-1:0] alu_wb_data,
  input  logic                 lu_valid,
  output logic                 lu_ready,
  input  logic [AW-1:0]        lu_addr,
  input  logic [CPU_WIDTH-1:0] lu_data,
  input  logic                 dbg_we,
  input  logic [AW-1:0]        dbg_addr,
  input  logic [CPU_WIDTH-1:0] dbg_data,
  output logic                 dbg_ack,
  output logic [AW-1:0]        WB_addr,
  output logic [CPU_WIDTH-1:0] WB_data,
  output logic                 RegWe,
  output logic [NREG-1:0]      busy,
  output logic                 err_orphan
);

  localparam int EW = AW + CPU_WIDTH;

  // Handshakes: a long result transfers on lu_valid & lu_ready; a debug write is held
  // by the requester until the single-cycle dbg_ack; ALU writeback is never refused.

  logic [NREG-1:0]      r_busy;
  logic                 r_err_orphan;
  logic [AW-1:0]        r_wb_addr;
  logic [CPU_WIDTH-1:0] r_wb_data;
  logic                 r_regwe;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_dbg_grant;
  logic                 w_issue_set;
  logic [EW-1:0]        w_head;
  logic [AW-1:0]        w_head_addr;
  logic [CPU_WIDTH-1:0] w_head_data;
  logic [NREG-1:0]      w_set_mask;
  logic [NREG-1:0]      w_clr_mask;
  wb_src_e              w_src;

  wb_fifo #(
    .W     (EW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({lu_addr, lu_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_addr = w_head[EW-1 -: AW];
  assign w_head_data = w_head[CPU_WIDTH-1:0];

  assign lu_ready = ~w_full;
  assign w_push   = lu_valid & ~w_full;
  assign w_pop    = ~alu_wb_valid & ~w_empty;
  // Gated by rst_n so no acknowledge escapes while the block is held in reset.
  assign w_dbg_grant = rst_n & dbg_we & ~alu_wb_valid & w_empty & ~r_busy[dbg_addr];
  assign dbg_ack     = w_dbg_grant;

  always_comb begin
    w_src = SRC_NONE;
    if (alu_wb_valid)     w_src = SRC_ALU;
    else if (!w_empty)    w_src = SRC_LQ;
    else if (w_dbg_grant) w_src = SRC_DBG;
  end

  // No same-cycle bypass of a clear: the stall releases one cycle after the pop.
  assign issue_stall = issue_valid & ((issue_uses_rd & r_busy[issue_rd])
                                    | (issue_uses_rs & r_busy[issue_rs])
                                    | (issue_writes  & r_busy[issue_rd]));

  assign w_issue_set = issue_valid & ~issue_stall & issue_writes & issue_long;
  assign w_set_mask  = w_issue_set ? reg_onehot(issue_rd) : '0;
  assign w_clr_mask  = w_pop ? reg_onehot(w_head_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
      if (w_push && !r_busy[lu_addr]) r_err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_regwe   <= ~REGWE_WRITE;
    end else begin
      r_regwe <= ~REGWE_WRITE;
      case (w_src)
        SRC_ALU: begin
          r_wb_addr <= alu_wb_addr;
          r_wb_data <= alu_wb_data;
          r_regwe   <= REGWE_WRITE;
        end
        SRC_LQ: begin
          r_wb_addr <= w_head_addr;
          r_wb_data <= w_head_data;
          r_regwe   <= REGWE_WRITE;
        end
        SRC_DBG: begin
          r_wb_addr <= dbg_addr;
          r_wb_data <= dbg_data;
          r_regwe   <= REGWE_WRITE;
        end
        default: ;
      endcase
    end
  end

  assign WB_addr    = r_wb_addr;
  assign WB_data    = r_wb_data;
  assign RegWe      = r_regwe;
  assign busy       = r_busy;
  assign err_orphan = r_err_orphan;

endmodule

// File: tb/tb_reg_wb_sched.sv
// Self-checking bench for reg_wb_sched: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the writeback rules.
module tb_reg_wb_sched;
  import reg_wb_sched_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        issue_rs;
  logic                 issue_uses_rd;
  logic                 issue_uses_rs;
  logic                 issue_writes;
  logic                 issue_long;
  logic                 issue_stall;
  logic                 alu_wb_valid;
  logic [AW-1:0]        alu_wb_addr;
  logic [CPU_WIDTH-1:0] alu_wb_data;
  logic                 lu_valid;
  logic                 lu_ready;
  logic [AW-1:0]        lu_addr;
  logic [CPU_WIDTH-1:0] lu_data;
  logic                 dbg_we;
  logic [AW-1:0]        dbg_addr;
  logic [CPU_WIDTH-1:0] dbg_data;
  logic                 dbg_ack;
  logic [AW-1:0]        WB_addr;
  logic [CPU_WIDTH-1:0] WB_data;
  logic                 RegWe;
  logic [NREG-1:0]      busy;
  logic                 err_orphan;

  int checks;
  int failures;

  reg_wb_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_rs      (issue_rs),
    .issue_uses_rd (issue_uses_rd),
    .issue_uses_rs (issue_uses_rs),
    .issue_writes  (issue_writes),
    .issue_long    (issue_long),
    .issue_stall   (issue_stall),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_addr   (alu_wb_addr),
    .alu_wb_data   (alu_wb_data),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_addr       (lu_addr),
    .lu_data       (lu_data),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .dbg_ack       (dbg_ack),
    .WB_addr       (WB_addr),
    .WB_data       (WB_data),
    .RegWe         (RegWe),
    .busy          (busy),
    .err_orphan    (err_orphan)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0; issue_rs = 0; issue_uses_rd = 0; issue_uses_rs = 0;
    issue_writes = 0; issue_long = 0;
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;
    dbg_we = 0; dbg_addr = 0; dbg_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  // Drivers
  task automatic drive_issue_long(input logic [AW-1:0] rd);
    issue_valid = 1; issue_rd = rd; issue_rs = 0; issue_uses_rd = 0; issue_uses_rs = 0;
    issue_writes = 1; issue_long = 1;
  endtask

  task automatic clear_issue();
    issue_valid = 0; issue_writes = 0; issue_long = 0; issue_uses_rd = 0; issue_uses_rs = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'($urandom); issue_rd = AW'($urandom); issue_rs = AW'($urandom);
      issue_uses_rd = 1'($urandom); issue_uses_rs = 1'($urandom);
      issue_writes = 1'($urandom); issue_long = 1'($urandom);
      alu_wb_valid = 1'($urandom); alu_wb_addr = AW'($urandom); alu_wb_data = 16'($urandom);
      lu_valid = 1'($urandom); lu_addr = AW'($urandom); lu_data = 16'($urandom);
      dbg_we = 1'($urandom); dbg_addr = AW'($urandom); dbg_data = 16'($urandom);
      tick();
      checks++;
      if (RegWe !== ~REGWE_WRITE) begin failures++; $display("FAIL reset_regwe: got %b expected %b", RegWe, ~REGWE_WRITE); end
      checks++;
      if (busy !== 8'h00) begin failures++; $display("FAIL reset_busy: got %h expected 00", busy); end
      checks++;
      if (lu_ready !== 1'b1) begin failures++; $display("FAIL reset_lu_ready: got %b expected 1", lu_ready); end
      checks++;
      if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_dbg_ack: got %b expected 0", dbg_ack); end
      checks++;
      if (WB_addr !== 3'd0 || WB_data !== 16'h0000 || err_orphan !== 1'b0) begin
        failures++; $display("FAIL reset_wb: got addr=%0d data=%h err=%b expected 0/0000/0", WB_addr, WB_data, err_orphan);
      end
    end
    idle_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu_wb();
    alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 16'h1234;
    tick();
    alu_wb_valid = 0;
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd3 || WB_data !== 16'h1234) begin
      failures++; $display("FAIL alu_wb_n1: got we=%b addr=%0d data=%h expected 1/3/1234", RegWe, WB_addr, WB_data);
    end
    tick();
    checks++;
    if (RegWe !== ~REGWE_WRITE || WB_addr !== 3'd3 || WB_data !== 16'h1234) begin
      failures++; $display("FAIL alu_wb_n2: got we=%b addr=%0d data=%h expected 0/3/1234 held", RegWe, WB_addr, WB_data);
    end
  endtask

  task automatic test_long_hazard();
    drive_issue_long(5);
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin failures++; $display("FAIL lh_first_issue: got stall=%b expected 0", issue_stall); end
    tick();
    issue_valid = 1; issue_rd = 0; issue_rs = 5; issue_uses_rd = 0; issue_uses_rs = 1;
    issue_writes = 1; issue_long = 0;
    #1;
    checks++;
    if (busy !== 8'h20) begin failures++; $display("FAIL lh_busy_set: got %h expected 20", busy); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (issue_stall !== 1'b1) begin failures++; $display("FAIL lh_stall_held: got %b expected 1", issue_stall); end
      tick();
    end
    lu_valid = 1; lu_addr = 5; lu_data = 16'hBEEF;
    #1;
    checks++;
    if (lu_ready !== 1'b1) begin failures++; $display("FAIL lh_lu_ready: got %b expected 1", lu_ready); end
    tick();
    lu_valid = 0;
    #1;
    checks++;
    if (issue_stall !== 1'b1 || RegWe !== ~REGWE_WRITE) begin
      failures++; $display("FAIL lh_push_plus1: got stall=%b we=%b expected 1/0", issue_stall, RegWe);
    end
    tick();
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd5 || WB_data !== 16'hBEEF) begin
      failures++; $display("FAIL lh_wb_plus2: got we=%b addr=%0d data=%h expected 1/5/beef", RegWe, WB_addr, WB_data);
    end
    checks++;
    if (busy !== 8'h00 || issue_stall !== 1'b0 || err_orphan !== 1'b0) begin
      failures++; $display("FAIL lh_release: got busy=%h stall=%b err=%b expected 00/0/0", busy, issue_stall, err_orphan);
    end
    clear_issue();
    tick();
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] rd_list [3];
    rd_list[0] = 1; rd_list[1] = 2; rd_list[2] = 6;
    for (int i = 0; i < 3; i++) begin
      drive_issue_long(rd_list[i]);
      tick();
    end
    clear_issue();
    #1;
    checks++;
    if (busy !== 8'h46) begin failures++; $display("FAIL ff_busy_setup: got %h expected 46", busy); end
    for (int c = 0; c < 4; c++) begin
      alu_wb_valid = 1; alu_wb_addr = 0; alu_wb_data = 16'(16'hA000 + c);
      lu_valid = 1; lu_addr = rd_list[(c < 2) ? c : 2]; lu_data = 16'(16'hC000 + lu_addr);
      #1;
      checks++;
      if (lu_ready !== (c < 2)) begin failures++; $display("FAIL ff_ready_c%0d: got %b expected %b", c, lu_ready, (c < 2)); end
      tick();
      checks++;
      if (RegWe !== REGWE_WRITE || WB_data !== 16'(16'hA000 + c)) begin
        failures++; $display("FAIL ff_alu_c%0d: got we=%b data=%h expected 1/%h", c, RegWe, WB_data, 16'(16'hA000 + c));
      end
    end
    alu_wb_valid = 0;
    #1;
    checks++;
    if (lu_ready !== 1'b0) begin failures++; $display("FAIL ff_ready_full_pop: got %b expected 0", lu_ready); end
    tick();
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd1 || WB_data !== 16'hC001 || lu_ready !== 1'b1) begin
      failures++; $display("FAIL ff_drain_r1: got we=%b addr=%0d data=%h ready=%b expected 1/1/c001/1", RegWe, WB_addr, WB_data, lu_ready);
    end
    tick();
    lu_valid = 0;
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd2 || WB_data !== 16'hC002) begin
      failures++; $display("FAIL ff_drain_r2: got we=%b addr=%0d data=%h expected 1/2/c002", RegWe, WB_addr, WB_data);
    end
    tick();
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd6 || WB_data !== 16'hC006 || busy !== 8'h00) begin
      failures++; $display("FAIL ff_drain_r6: got we=%b addr=%0d data=%h busy=%h expected 1/6/c006/00", RegWe, WB_addr, WB_data, busy);
    end
    tick();
  endtask

  task automatic test_debug();
    drive_issue_long(1);
    tick();
    clear_issue();
    dbg_we = 1; dbg_addr = 4; dbg_data = 16'h00FF;
    alu_wb_valid = 1; alu_wb_addr = 2; alu_wb_data = 16'h2222;
    lu_valid = 1; lu_addr = 1; lu_data = 16'h1111;
    #1;
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_alu_busy: got %b expected 0", dbg_ack); end
    tick();
    lu_valid = 0;
    #1;
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_alu_fifo: got %b expected 0", dbg_ack); end
    tick();
    alu_wb_valid = 0;
    #1;
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_fifo: got %b expected 0", dbg_ack); end
    tick();
    #1;
    checks++;
    if (dbg_ack !== 1'b1 || WB_addr !== 3'd1 || WB_data !== 16'h1111) begin
      failures++; $display("FAIL dbg_ack_grant: got ack=%b addr=%0d data=%h expected 1/1/1111", dbg_ack, WB_addr, WB_data);
    end
    tick();
    dbg_we = 0;
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd4 || WB_data !== 16'h00FF) begin
      failures++; $display("FAIL dbg_wb: got we=%b addr=%0d data=%h expected 1/4/00ff", RegWe, WB_addr, WB_data);
    end
    #1;
    checks++;
    if (dbg_ack !== 1'b0) begin failures++; $display("FAIL dbg_ack_single: got %b expected 0", dbg_ack); end
    tick();
  endtask

  // Behavioural model: a queue of pending long results and a per-register busy flag.
  typedef struct {
    logic [AW-1:0]        a;
    logic [CPU_WIDTH-1:0] d;
  } lq_ent_t;

  task automatic test_random();
    lq_ent_t              lq [$];
    lq_ent_t              ent;
    bit                   m_busy [NREG];
    bit                   m_err;
    logic                 m_we;
    logic [AW-1:0]        m_addr;
    logic [CPU_WIDTH-1:0] m_data;
    bit                   exp_stall, exp_ready, exp_ack, dbg_pending;
    logic [NREG-1:0]      exp_busy;
    int                   cand [$];

    do_reset();
    for (int r = 0; r < NREG; r++) m_busy[r] = 0;
    m_err = 0; m_we = ~REGWE_WRITE; m_addr = 0; m_data = 0; dbg_pending = 0;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = AW'($urandom); issue_rs = AW'($urandom);
      issue_uses_rd = 1'($urandom); issue_uses_rs = 1'($urandom);
      issue_writes = 1'($urandom); issue_long = ($urandom_range(0, 9) < 4);
      alu_wb_valid = ($urandom_range(0, 9) < 4);
      alu_wb_addr = AW'($urandom); alu_wb_data = 16'($urandom);
      cand.delete();
      for (int r = 0; r < NREG; r++) if (m_busy[r]) cand.push_back(r);
      lu_valid = ($urandom_range(0, 9) < 5);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8)
        lu_addr = AW'(cand[$urandom_range(0, cand.size() - 1)]);
      else
        lu_addr = AW'($urandom);
      lu_data = 16'($urandom);
      if (!dbg_pending && $urandom_range(0, 9) < 2) begin
        dbg_pending = 1; dbg_addr = AW'($urandom); dbg_data = 16'($urandom);
      end
      dbg_we = dbg_pending;
      #1;

      exp_stall = issue_valid && ((issue_uses_rd && m_busy[issue_rd])
                               || (issue_uses_rs && m_busy[issue_rs])
                               || (issue_writes && m_busy[issue_rd]));
      exp_ready = (lq.size() < LQ_DEPTH_DEFAULT);
      exp_ack   = dbg_we && !alu_wb_valid && lq.size() == 0 && !m_busy[dbg_addr];
      checks++;
      if (issue_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc%0d: got %b expected %b", cyc, issue_stall, exp_stall); end
      checks++;
      if (lu_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc%0d: got %b expected %b", cyc, lu_ready, exp_ready); end
      checks++;
      if (dbg_ack !== exp_ack) begin failures++; $display("FAIL rnd_ack cyc%0d: got %b expected %b", cyc, dbg_ack, exp_ack); end

      m_we = ~REGWE_WRITE;
      if (alu_wb_valid) begin
        m_we = REGWE_WRITE; m_addr = alu_wb_addr; m_data = alu_wb_data;
      end else if (lq.size() > 0) begin
        ent = lq.pop_front();
        m_we = REGWE_WRITE; m_addr = ent.a; m_data = ent.d;
        if (lu_valid && exp_ready && !m_busy[lu_addr]) m_err = 1;
        m_busy[ent.a] = 0;
      end else if (exp_ack) begin
        m_we = REGWE_WRITE; m_addr = dbg_addr; m_data = dbg_data;
        dbg_pending = 0;
      end
      if (lu_valid && exp_ready) begin
        if (!alu_wb_valid && lq.size() == 0 && !m_busy[lu_addr]) m_err = 1;
        if (alu_wb_valid && !m_busy[lu_addr]) m_err = 1;
        ent.a = lu_addr; ent.d = lu_data;
        lq.push_back(ent);
      end
      if (issue_valid && !exp_stall && issue_writes && issue_long) m_busy[issue_rd] = 1;

      tick();
      for (int r = 0; r < NREG; r++) exp_busy[r] = m_busy[r];
      checks++;
      if (RegWe !== m_we || WB_addr !== m_addr || WB_data !== m_data) begin
        failures++; $display("FAIL rnd_wb cyc%0d: got we=%b addr=%0d data=%h expected %b/%0d/%h", cyc, RegWe, WB_addr, WB_data, m_we, m_addr, m_data);
      end
      checks++;
      if (busy !== exp_busy || err_orphan !== m_err) begin
        failures++; $display("FAIL rnd_sb cyc%0d: got busy=%h err=%b expected %h/%b", cyc, busy, err_orphan, exp_busy, m_err);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_orphan_reset();
    do_reset();
    lu_valid = 1; lu_addr = 7; lu_data = 16'h7777;
    tick();
    lu_valid = 0;
    checks++;
    if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set: got %b expected 1", err_orphan); end
    tick();
    checks++;
    if (RegWe !== REGWE_WRITE || WB_addr !== 3'd7 || WB_data !== 16'h7777 || busy !== 8'h00) begin
      failures++; $display("FAIL orphan_wb: got we=%b addr=%0d data=%h busy=%h expected 1/7/7777/00", RegWe, WB_addr, WB_data, busy);
    end
    drive_issue_long(1);
    tick();
    drive_issue_long(2);
    tick();
    clear_issue();
    alu_wb_valid = 1; alu_wb_addr = 0; alu_wb_data = 16'h5555;
    lu_valid = 1; lu_addr = 1; lu_data = 16'h0101;
    tick();
    lu_addr = 2; lu_data = 16'h0202;
    tick();
    lu_valid = 0; alu_wb_valid = 0;
    tick();
    checks++;
    if (err_orphan !== 1'b1 || busy !== 8'h04) begin
      failures++; $display("FAIL orphan_sticky: got err=%b busy=%h expected 1/04", err_orphan, busy);
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (busy !== 8'h00 || lu_ready !== 1'b1 || err_orphan !== 1'b0 || RegWe !== ~REGWE_WRITE) begin
      failures++; $display("FAIL midreset_clear: got busy=%h ready=%b err=%b we=%b expected 00/1/0/0", busy, lu_ready, err_orphan, RegWe);
    end
    tick();
    rst_n = 1;
    tick();
    tick();
    checks++;
    if (RegWe !== ~REGWE_WRITE || WB_addr !== 3'd0 || busy !== 8'h00) begin
      failures++; $display("FAIL midreset_no_drain: got we=%b addr=%0d busy=%h expected 0/0/00", RegWe, WB_addr, busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_alu_wb();
    test_long_hazard();
    test_fifo_full();
    test_debug();
    test_random();
    test_orphan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
